// File: rtl/rx_medida_7e1.sv
// rx_medida_7e1: 7E1 UART receiver that reassembles "ddd#" frames into a 12-bit BCD measurement.
module rx_medida_7e1 #(
  parameter int DIVISOR = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [6:0]  db_caractere,
  output logic [3:0]  db_estado
);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF_T = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_T = CW'(DIVISOR - 1);
  typedef enum logic [3:0] {INICIAL, START, DADOS, PARIDADE, PARADA, AVALIA} state_t;
  state_t st_q, st_d;
  logic s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bc_q, bc_d;
  logic [6:0] sh_q, sh_d, chr_q, chr_d;
  logic par_q, par_d, stop_q, stop_d;
  logic [1:0] idx_q, idx_d;
  logic [11:0] stg_q, stg_d, med_q, med_d;
  logic pronto_q, pronto_d, erro_q, erro_d;
  logic ok, digit, hash, full;
  assign ok = (par_q == ^sh_q) && stop_q;
  assign digit = sh_q[6:4] == 3'b011 && sh_q[3:0] <= 4'd9;
  assign hash = sh_q == 7'h23;
  assign full = cnt_q == FULL_T;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
      st_q <= INICIAL;
      cnt_q <= '0;
      bc_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      idx_q <= '0;
      stg_q <= '0;
      med_q <= '0;
      chr_q <= '0;
      pronto_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      s1_q <= entrada_serial;
      s2_q <= s1_q;
      prev_q <= s2_q;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bc_q <= bc_d;
      sh_q <= sh_d;
      par_q <= par_d;
      stop_q <= stop_d;
      idx_q <= idx_d;
      stg_q <= stg_d;
      med_q <= med_d;
      chr_q <= chr_d;
      pronto_q <= pronto_d;
      erro_q <= erro_d;
    end
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + CW'(1);
    bc_d = bc_q;
    sh_d = sh_q;
    par_d = par_q;
    stop_d = stop_q;
    idx_d = idx_q;
    stg_d = stg_q;
    med_d = med_q;
    chr_d = chr_q;
    pronto_d = 1'b0;
    erro_d = 1'b0;
    case (st_q)
      INICIAL: if (prev_q && !s2_q) begin
        st_d = START;
        cnt_d = '0;
      end
      START: if (cnt_q == HALF_T) begin
        cnt_d = '0;
        bc_d = '0;
        st_d = s2_q ? INICIAL : DADOS;
      end
      DADOS: if (full) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[6:1]};
        bc_d = bc_q + 3'd1;
        st_d = bc_q == 3'd6 ? PARIDADE : DADOS;
      end
      PARIDADE: if (full) begin
        cnt_d = '0;
        par_d = s2_q;
        st_d = PARADA;
      end
      PARADA: if (full) begin
        cnt_d = '0;
        stop_d = s2_q;
        st_d = AVALIA;
      end
      AVALIA: begin
        st_d = INICIAL;
        chr_d = sh_q;
        // staging nibble order: idx 0 -> hundreds, 1 -> tens, 2 -> units
        if (ok && idx_q != 2'd3 && digit) begin
          stg_d = idx_q == 2'd0 ? {sh_q[3:0], stg_q[7:0]} :
                  idx_q == 2'd1 ? {stg_q[11:8], sh_q[3:0], stg_q[3:0]} : {stg_q[11:4], sh_q[3:0]};
          idx_d = idx_q + 2'd1;
        end else if (ok && idx_q == 2'd3 && hash) begin
          med_d = stg_q;
          pronto_d = 1'b1;
          idx_d = '0;
        end else begin
          erro_d = 1'b1;
          idx_d = '0;
        end
      end
      default: st_d = INICIAL;
    endcase
  end
  assign medida = med_q;
  assign pronto = pronto_q;
  assign erro = erro_q;
  assign db_caractere = chr_q;
  assign db_estado = st_q;
endmodule
